// File: rtl/alu_operand_stage.sv
// Operand-fetch / result-writeback stage around an external combinational 32-bit ALU.
// Define ALU_OPERAND_FWD_EN to bypass the in-flight result to a dependent command instead of stalling.
module alu_operand_stage #(
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rs1,
  input  logic [REG_AW-1:0] cmd_rs2,
  input  logic              cmd_imm_en,
  input  logic [31:0]       cmd_imm,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [3:0]        alu_control,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [REG_AW-1:0] res_rd,
  output logic              res_zero,
  output logic [31:0]       ops_retired
);

  localparam int NREG = 1 << REG_AW;

  logic              iss_valid_q, iss_valid_d;
  logic [31:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]        alu_control_q, alu_control_d;
  logic [REG_AW-1:0] iss_rd_q, iss_rd_d;
  logic              res_valid_q, res_valid_d;
  logic [31:0]       res_data_q, res_data_d;
  logic [REG_AW-1:0] res_rd_q, res_rd_d;
  logic              res_zero_q, res_zero_d;
  logic [31:0]       ops_retired_q, ops_retired_d;
  logic [31:0]       rf_q [NREG];
  logic [31:0]       rf_d [NREG];

  logic              res_load, iss_advance, wb_en, hazard, cmd_fire;
  logic [31:0]       rs1_val, rs2_val;

  assign res_load    = iss_valid_q & (~res_valid_q | res_ready);
  assign iss_advance = ~iss_valid_q | res_load;
  assign wb_en       = res_load & (iss_rd_q != '0);

`ifdef ALU_OPERAND_FWD_EN
  assign hazard = 1'b0;
`else
  // Without a bypass, a command reading the in-flight destination waits for writeback.
  assign hazard = iss_valid_q & (iss_rd_q != '0) &
                  ((cmd_rs1 == iss_rd_q) | (~cmd_imm_en & (cmd_rs2 == iss_rd_q)));
`endif

  assign cmd_ready = iss_advance & ~hazard;
  assign cmd_fire  = cmd_valid & cmd_ready;

  always_comb begin
    rs1_val = rf_q[cmd_rs1];
    rs2_val = rf_q[cmd_rs2];
`ifdef ALU_OPERAND_FWD_EN
    if (wb_en && (iss_rd_q == cmd_rs1)) rs1_val = alu_result;
    if (wb_en && (iss_rd_q == cmd_rs2)) rs2_val = alu_result;
`endif
    if (cmd_rs1 == '0) rs1_val = '0;
    if (cmd_rs2 == '0) rs2_val = '0;
  end

  always_comb begin
    iss_valid_d   = iss_valid_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_control_d = alu_control_q;
    iss_rd_d      = iss_rd_q;
    if (cmd_fire) begin
      iss_valid_d   = 1'b1;
      alu_a_d       = rs1_val;
      alu_b_d       = cmd_imm_en ? cmd_imm : rs2_val;
      alu_control_d = cmd_op;
      iss_rd_d      = cmd_rd;
    end else if (res_load) begin
      iss_valid_d = 1'b0;
    end
  end

  always_comb begin
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_rd_d      = res_rd_q;
    res_zero_d    = res_zero_q;
    ops_retired_d = ops_retired_q;
    rf_d          = rf_q;
    if (res_load) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_result;
      res_rd_d    = iss_rd_q;
      res_zero_d  = alu_zero;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
    if (res_valid_q && res_ready) ops_retired_d = ops_retired_q + 32'd1;
    if (wb_en) rf_d[iss_rd_q] = alu_result;
  end

  // ISSUE and RESULT stage registers plus register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid_q   <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_control_q <= '0;
      iss_rd_q      <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_rd_q      <= '0;
      res_zero_q    <= 1'b0;
      ops_retired_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      iss_valid_q   <= iss_valid_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_control_q <= alu_control_d;
      iss_rd_q      <= iss_rd_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_rd_q      <= res_rd_d;
      res_zero_q    <= res_zero_d;
      ops_retired_q <= ops_retired_d;
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_control_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_rd      = res_rd_q;
  assign res_zero    = res_zero_q;
  assign ops_retired = ops_retired_q;

endmodule
